// File: rtl/nic_host_port.sv
`default_nettype none
// ============================================================================
// Module   : nic_host_port
// Purpose  : Processor-side master for one ring NIC register interface.
//            Takes outbound packets from a valid/ready stream and writes
//            them into the NIC output-channel buffer once the output status
//            reports not-full. Polls the NIC input status and drains inbound
//            packets onto a valid/ready stream.
// Ports    : clk, rst              - clock, synchronous active-high reset
//            addr/d_in/nicEN/nicWrEn/d_out - NIC register bus (outputs regd)
//            tx_valid/tx_ready/tx_data     - outbound packet stream
//            rx_valid/rx_ready/rx_data     - inbound packet stream
//            tx_count/rx_count             - wrapping packet counters
// Revision : 1.0 - initial release
// ============================================================================
module nic_host_port #(
  parameter int DATA_W   = 64,
  parameter int CNT_W    = 16,
  parameter int POLL_GAP = 0
) (
  input  logic              clk,
  input  logic              rst,
  output logic [1:0]        addr,
  output logic [DATA_W-1:0] d_in,
  output logic              nicEN,
  output logic              nicWrEn,
  input  logic [DATA_W-1:0] d_out,
  input  logic              tx_valid,
  output logic              tx_ready,
  input  logic [DATA_W-1:0] tx_data,
  output logic              rx_valid,
  input  logic              rx_ready,
  output logic [DATA_W-1:0] rx_data,
  output logic [CNT_W-1:0]  tx_count,
  output logic [CNT_W-1:0]  rx_count
);

  localparam logic [1:0] ADDR_IN_BUF   = 2'd0;
  localparam logic [1:0] ADDR_IN_STAT  = 2'd1;
  localparam logic [1:0] ADDR_OUT_BUF  = 2'd2;
  localparam logic [1:0] ADDR_OUT_STAT = 2'd3;

  localparam int GAP_W = (POLL_GAP > 0) ? $clog2(POLL_GAP + 1) : 1;
  localparam logic [GAP_W-1:0] GAP_END = GAP_W'((POLL_GAP > 0) ? POLL_GAP - 1 : 0);

  typedef enum logic [3:0] {
    IDLE    = 4'd0,
    TX_POLL = 4'd1,
    TX_CHK  = 4'd2,
    TX_WR   = 4'd3,
    RX_POLL = 4'd4,
    RX_CHK  = 4'd5,
    RX_RD   = 4'd6,
    RX_CAP  = 4'd7,
    GAP     = 4'd8
  } state_t;

  state_t             state;
  logic [DATA_W-1:0]  hold;      // outbound holding register
  logic               prio;      // 0 = TX wins a tie, 1 = RX wins a tie
  logic [GAP_W-1:0]   gap_cnt;

  // Holding register is full exactly when tx_ready is low.
  logic tx_elig;
  logic rx_elig;
  logic tx_grant;
  logic rx_grant;

  assign tx_elig  = ~tx_ready;
  assign rx_elig  = ~rx_valid;
  assign tx_grant = tx_elig & (~rx_elig | ~prio);
  assign rx_grant = rx_elig & (~tx_elig |  prio);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      addr     <= ADDR_IN_BUF;
      d_in     <= '0;
      nicEN    <= 1'b0;
      nicWrEn  <= 1'b0;
      tx_ready <= 1'b1;
      rx_valid <= 1'b0;
      rx_data  <= '0;
      tx_count <= '0;
      rx_count <= '0;
      hold     <= '0;
      prio     <= 1'b0;
      gap_cnt  <= '0;
    end else begin
      // Every access is a single-cycle strobe; states that issue one
      // re-assert it below.
      nicEN   <= 1'b0;
      nicWrEn <= 1'b0;

      if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end

      if (tx_valid && tx_ready) begin
        hold     <= tx_data;
        tx_ready <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (tx_grant) begin
            state <= TX_POLL;
            nicEN <= 1'b1;
            addr  <= ADDR_OUT_STAT;
            prio  <= ~prio;
          end else if (rx_grant) begin
            state <= RX_POLL;
            nicEN <= 1'b1;
            addr  <= ADDR_IN_STAT;
            prio  <= ~prio;
          end
        end

        // Read data for a request issued in the POLL/RD cycle is valid at the
        // end of the following cycle, which is why every read is followed by
        // a CHK/CAP state that samples d_out.
        TX_POLL: state <= TX_CHK;

        TX_CHK: begin
          if (d_out[0]) begin
            state   <= (POLL_GAP == 0) ? IDLE : GAP;
            gap_cnt <= '0;
          end else begin
            state   <= TX_WR;
            nicEN   <= 1'b1;
            nicWrEn <= 1'b1;
            addr    <= ADDR_OUT_BUF;
            d_in    <= hold;
          end
        end

        TX_WR: begin
          tx_count <= tx_count + 1'b1;
          tx_ready <= 1'b1;
          state    <= IDLE;
        end

        RX_POLL: state <= RX_CHK;

        RX_CHK: begin
          if (!d_out[0]) begin
            state   <= (POLL_GAP == 0) ? IDLE : GAP;
            gap_cnt <= '0;
          end else begin
            state <= RX_RD;
            nicEN <= 1'b1;
            addr  <= ADDR_IN_BUF;
          end
        end

        RX_RD: state <= RX_CAP;

        RX_CAP: begin
          rx_data  <= d_out;
          rx_valid <= 1'b1;
          rx_count <= rx_count + 1'b1;
          state    <= IDLE;
        end

        GAP: begin
          if (gap_cnt == GAP_END) begin
            gap_cnt <= '0;
            state   <= IDLE;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_nic_host_port.sv
`default_nettype none
// ============================================================================
// Module   : tb_nic_host_port
// Purpose  : Self-checking bench for nic_host_port. A behavioural NIC
//            (single-entry input and output buffers, one-cycle read latency)
//            answers the bus, and a packet-level scoreboard predicts both
//            streams, the counters and the arbitration order.
// Revision : 1.0 - initial release
// ============================================================================
module tb_nic_host_port;

  localparam int DATA_W   = 64;
  localparam int CNT_W    = 4;
  localparam int POLL_GAP = 2;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [1:0]        addr;
  logic [DATA_W-1:0] d_in;
  logic              nicEN;
  logic              nicWrEn;
  logic [DATA_W-1:0] d_out = '0;
  logic              tx_valid = 1'b0;
  logic              tx_ready;
  logic [DATA_W-1:0] tx_data = '0;
  logic              rx_valid;
  logic              rx_ready = 1'b0;
  logic [DATA_W-1:0] rx_data;
  logic [CNT_W-1:0]  tx_count;
  logic [CNT_W-1:0]  rx_count;

  nic_host_port #(.DATA_W(DATA_W), .CNT_W(CNT_W), .POLL_GAP(POLL_GAP)) dut (
    .clk(clk), .rst(rst), .addr(addr), .d_in(d_in), .nicEN(nicEN),
    .nicWrEn(nicWrEn), .d_out(d_out), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .tx_data(tx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .rx_data(rx_data), .tx_count(tx_count), .rx_count(rx_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // NIC environment state
  logic        out_full  = 1'b0;
  logic        out_force = 1'b0;
  logic        in_full   = 1'b0;
  logic [63:0] in_data   = '0;
  int          drain_pct = 100;
  int          fill_pct  = 0;
  logic        have_pend = 1'b0;
  logic        pend_rx0  = 1'b0;
  logic [63:0] pend_val  = '0;

  // Scoreboard
  logic [63:0] tx_q[$];
  logic [63:0] rx_q[$];
  int          tx_done  = 0;
  int          rxc_exp  = 0;
  int          tx_polls = 0;
  int          both_cnt = 0;
  logic        prio     = 1'b0;
  logic        prev_valid = 1'b0;
  logic        prev_txe = 1'b0;
  logic        prev_rxe = 1'b0;
  logic        prev_en  = 1'b0;

  always @(negedge clk) begin
    logic        cap_now;
    logic [63:0] cap_val;
    logic        grant_tx;
    if (rst) begin
      tx_q.delete();
      rx_q.delete();
      tx_done    = 0;
      rxc_exp    = 0;
      prio       = 1'b0;
      prev_valid = 1'b0;
      prev_en    = 1'b0;
      have_pend  = 1'b0;
    end else begin
      cap_now = 1'b0;
      cap_val = '0;
      if (have_pend) begin
        d_out     = pend_val;
        have_pend = 1'b0;
        cap_now   = pend_rx0;
        cap_val   = pend_val;
      end

      check("tx_ready", 64'(tx_ready), 64'(tx_q.size() == 0));
      check("rx_valid", 64'(rx_valid), 64'(rx_q.size() != 0));
      if (rx_valid && rx_q.size() != 0) check("rx_data", rx_data, rx_q[0]);
      check("tx_count", 64'(tx_count), 64'(tx_done & 15));
      check("rx_count", 64'(rx_count), 64'(rxc_exp & 15));
      if (nicEN) check("en_back_to_back", 64'(prev_en), 64'd0);

      if (nicEN && nicWrEn) begin
        check("wr_addr", 64'(addr), 64'd2);
        check("wr_while_full", 64'(out_full | out_force), 64'd0);
        if (tx_q.size() != 0) check("wr_data", d_in, tx_q.pop_front());
        else check("wr_spurious", 64'(tx_q.size()), 64'd1);
        out_full = 1'b1;
        tx_done++;
      end

      if (nicEN && !nicWrEn) begin
        if (addr == 2'd1) check("rx_poll_while_pending", 64'(rx_valid), 64'd0);
        if (addr == 2'd1 || addr == 2'd3) begin
          grant_tx = (addr == 2'd3);
          if (prev_valid) begin
            check("grant_eligible", 64'(grant_tx ? prev_txe : prev_rxe), 64'd1);
            if (prev_txe && prev_rxe) begin
              both_cnt++;
              check("grant_prio", 64'(grant_tx), 64'(!prio));
            end
          end
          prio = ~prio;
          if (grant_tx) tx_polls++;
        end
        pend_rx0 = 1'b0;
        case (addr)
          2'd0: begin
            check("rd_empty_in_buf", 64'(in_full), 64'd1);
            pend_val = in_data;
            pend_rx0 = 1'b1;
            in_full  = 1'b0;
          end
          2'd1:    pend_val = {$urandom, $urandom_range(32'h7fff_ffff, 0), in_full};
          2'd3:    pend_val = {$urandom, $urandom_range(32'h7fff_ffff, 0), out_full | out_force};
          default: pend_val = {$urandom, $urandom};
        endcase
        have_pend = 1'b1;
        d_out     = {$urandom, $urandom};
      end

      if (cap_now) begin
        rx_q.push_back(cap_val);
        rxc_exp++;
      end
      if (tx_valid && tx_ready) tx_q.push_back(tx_data);
      if (rx_valid && rx_ready && rx_q.size() != 0) void'(rx_q.pop_front());

      prev_txe   = ~tx_ready;
      prev_rxe   = ~rx_valid;
      prev_valid = 1'b1;
      prev_en    = nicEN;

      if (out_full && !out_force && ($urandom % 100) < drain_pct) out_full = 1'b0;
      if (!in_full && ($urandom % 100) < fill_pct) begin
        in_full = 1'b1;
        in_data = {$urandom, $urandom};
      end
    end
  end

  task automatic check_reset_values(input string tag);
    check({tag, "_addr"},     64'(addr), 64'd0);
    check({tag, "_d_in"},     d_in, 64'd0);
    check({tag, "_nicEN"},    64'(nicEN), 64'd0);
    check({tag, "_nicWrEn"},  64'(nicWrEn), 64'd0);
    check({tag, "_tx_ready"}, 64'(tx_ready), 64'd1);
    check({tag, "_rx_valid"}, 64'(rx_valid), 64'd0);
    check({tag, "_rx_data"},  rx_data, 64'd0);
    check({tag, "_tx_count"}, 64'(tx_count), 64'd0);
    check({tag, "_rx_count"}, 64'(rx_count), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic got;
    logic low_ok;
    int   p0;
    int   d0;

    // Reset values
    in_full = 1'b1;
    in_data = 64'h0000_0000_DEAD_BEEF;
    repeat (3) @(posedge clk);
    #1;
    check_reset_values("reset");
    rst = 1'b0;

    // Inbound packet held while the consumer stalls
    got = 1'b0;
    for (int i = 0; i < 50 && !got; i++) begin
      @(posedge clk); #1;
      if (rx_valid) got = 1'b1;
    end
    check("rx_arrive_wait", 64'(got), 64'd1);
    check("rx_first_data", rx_data, 64'h0000_0000_DEAD_BEEF);
    check("rx_first_count", 64'(rx_count), 64'd1);

    // Minimum TX latency (FSM idles because RX is pending)
    tx_valid = 1'b1;
    tx_data  = 64'hA5A5_0000_0000_0001;
    @(posedge clk); #1;
    tx_valid = 1'b0;
    tx_data  = {$urandom, $urandom};
    check("lat_accept_ready", 64'(tx_ready), 64'd0);
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk); #1;
      tx_data = {$urandom, $urandom};
      if (k == 1) check("lat_poll", 64'({nicEN, nicWrEn, addr}), 64'({1'b1, 1'b0, 2'd3}));
      if (k == 2) check("lat_chk_idle_bus", 64'(nicEN), 64'd0);
      if (k == 3) begin
        check("lat_write", 64'({nicEN, nicWrEn, addr}), 64'({1'b1, 1'b1, 2'd2}));
        check("lat_write_data", d_in, 64'hA5A5_0000_0000_0001);
      end
      if (k == 4) begin
        check("lat_ready_back", 64'(tx_ready), 64'd1);
        check("lat_tx_count", 64'(tx_count), 64'd1);
      end
    end
    check("rx_held_valid", 64'(rx_valid), 64'd1);
    check("rx_held_data", rx_data, 64'h0000_0000_DEAD_BEEF);
    rx_ready = 1'b1;
    @(posedge clk); #1;
    rx_ready = 1'b0;
    check("rx_consumed", 64'(rx_valid), 64'd0);

    // Output buffer full for 10 polls, then cleared
    out_force = 1'b1;
    tx_valid  = 1'b1;
    tx_data   = 64'h1111_2222_3333_4444;
    @(posedge clk); #1;
    tx_valid = 1'b0;
    p0 = tx_polls;
    d0 = tx_done;
    low_ok = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 400 && !got; i++) begin
      @(posedge clk); #1;
      tx_data = {$urandom, $urandom};
      if (tx_ready) low_ok = 1'b0;
      if (tx_polls - p0 >= 10) got = 1'b1;
    end
    check("full_polls_wait", 64'(got), 64'd1);
    check("full_ready_low", 64'(low_ok), 64'd1);
    check("full_no_write", 64'(tx_done - d0), 64'd0);
    out_force = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 60 && !got; i++) begin
      @(posedge clk); #1;
      if (tx_ready) got = 1'b1;
    end
    check("full_release_wait", 64'(got), 64'd1);
    check("full_one_write", 64'(tx_done - d0), 64'd1);

    // Reset during TX_CHK: the pending write must never appear
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(posedge clk); #1;
      if (!out_full) got = 1'b1;
    end
    check("drain_wait", 64'(got), 64'd1);
    tx_valid = 1'b1;
    tx_data  = 64'h2222_2222_2222_2222;
    @(posedge clk); #1;
    tx_valid = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 50 && !got; i++) begin
      if (nicEN && !nicWrEn && addr == 2'd3) got = 1'b1;
      else begin @(posedge clk); #1; end
    end
    check("rst_poll_wait", 64'(got), 64'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check_reset_values("midrst");
    @(posedge clk); #1;
    rst = 1'b0;

    // Randomized traffic
    fill_pct  = 30;
    drain_pct = 30;
    for (int i = 0; i < 3000; i++) begin
      tx_valid = ($urandom % 2) == 0;
      tx_data  = {$urandom, $urandom};
      rx_ready = ($urandom % 3) != 0;
      @(posedge clk); #1;
    end
    tx_valid  = 1'b0;
    rx_ready  = 1'b1;
    fill_pct  = 0;
    drain_pct = 100;
    repeat (200) @(posedge clk);
    #1;
    check("end_tx_queue_empty", 64'(tx_q.size()), 64'd0);
    check("end_rx_queue_empty", 64'(rx_q.size()), 64'd0);
    check("end_in_buf_drained", 64'(in_full), 64'd0);
    check("end_tx_wrapped", 64'(tx_done > 16), 64'd1);
    check("end_both_eligible_seen", 64'(both_cnt > 0), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
